// File: rtl/pdm_mic_receiver.sv
// -----------------------------------------------------------------------------
// pdm_mic_receiver
//
// Generates the PDM microphone bit clock and samples the 1-bit PDM stream. The
// stream is converted to unsigned amplitude words by counting ones over a
// window of W = 2^WINDOW_BITS - 1 mic-clock ticks. Two accumulators run on
// windows staggered by half a window. Together they give a fresh amplitude
// roughly every 2^(WINDOW_BITS-1) ticks.
//
// Parameters:
//   HALF_PERIOD  system clock cycles per half mic-clock period (>= 2)
//   WINDOW_BITS  amplitude width (>= 2); window length W = 2^WINDOW_BITS - 1
//
// Ports:
//   clk              system clock
//   rst              synchronous active-high reset
//   m_clk            microphone bit clock (50% duty)
//   m_clk_en         one-cycle pulse coincident with each rising edge of m_clk
//   m_data           PDM data from the microphone, asynchronous to clk
//   m_lr_sel         channel select, constant 0 (data valid at m_clk rise)
//   amplitude        count of ones in the last completed window
//   amplitude_valid  one-cycle strobe marking a new amplitude
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pdm_mic_receiver #(
    parameter int HALF_PERIOD = 21,
    parameter int WINDOW_BITS = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   m_clk,
    output logic                   m_clk_en,
    input  logic                   m_data,
    output logic                   m_lr_sel,
    output logic [WINDOW_BITS-1:0] amplitude,
    output logic                   amplitude_valid
);

    localparam int DIV_W = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(HALF_PERIOD - 1);
    // Last tick index of a window: W - 1 = 2^WINDOW_BITS - 2.
    localparam logic [WINDOW_BITS-1:0] T_LAST   = WINDOW_BITS'((2 ** WINDOW_BITS) - 2);
    // Accumulator B is offset by half a window.
    localparam logic [WINDOW_BITS-1:0] B_START  = WINDOW_BITS'(2 ** (WINDOW_BITS - 1));
    localparam logic [WINDOW_BITS-1:0] B_CLOSE  = WINDOW_BITS'((2 ** (WINDOW_BITS - 1)) - 1);

    logic [DIV_W-1:0]       div_r;
    logic                   m_clk_r;
    logic                   m_clk_en_r;
    logic                   sync_meta_r;
    logic                   d_sync_r;
    logic [WINDOW_BITS-1:0] t_r;
    logic [WINDOW_BITS-1:0] acc_a_r;
    logic [WINDOW_BITS-1:0] acc_b_r;
    logic                   b_primed_r;
    logic [WINDOW_BITS-1:0] amplitude_r;
    logic                   amplitude_valid_r;

    logic                   div_wrap_s;
    logic [WINDOW_BITS-1:0] bit_ext_s;
    logic [WINDOW_BITS-1:0] sum_a_s;
    logic [WINDOW_BITS-1:0] sum_b_s;
    logic                   close_a_s;
    logic                   close_b_s;

    logic [DIV_W-1:0]       div_nxt_s;
    logic                   m_clk_nxt_s;
    logic                   m_clk_en_nxt_s;
    logic [WINDOW_BITS-1:0] t_nxt_s;
    logic [WINDOW_BITS-1:0] acc_a_nxt_s;
    logic [WINDOW_BITS-1:0] acc_b_nxt_s;
    logic                   b_primed_nxt_s;
    logic [WINDOW_BITS-1:0] amplitude_nxt_s;
    logic                   amplitude_valid_nxt_s;

    assign m_clk           = m_clk_r;
    assign m_clk_en        = m_clk_en_r;
    assign m_lr_sel        = 1'b0;
    assign amplitude       = amplitude_r;
    assign amplitude_valid = amplitude_valid_r;

    // Decode of the divider wrap and of the window-closing ticks.
    always_comb begin
        div_wrap_s = (div_r == DIV_LAST);
        // The sampled bit is the synchronized data in the m_clk_en cycle. An
        // accumulator holds at most W-1 before its last add, so the sum fits.
        bit_ext_s  = WINDOW_BITS'(d_sync_r);
        sum_a_s    = acc_a_r + bit_ext_s;
        sum_b_s    = acc_b_r + bit_ext_s;
        close_a_s  = m_clk_en_r && (t_r == T_LAST);
        close_b_s  = m_clk_en_r && (t_r == B_CLOSE);
    end

    // Mic clock divider: toggle on wrap. Flag the rising edge for one cycle.
    always_comb begin
        if (div_wrap_s) begin
            div_nxt_s      = {DIV_W{1'b0}};
            m_clk_nxt_s    = ~m_clk_r;
            m_clk_en_nxt_s = ~m_clk_r;
        end else begin
            div_nxt_s      = div_r + DIV_W'(1);
            m_clk_nxt_s    = m_clk_r;
            m_clk_en_nxt_s = 1'b0;
        end
    end

    // Tick counter and both window accumulators, advanced on each sample tick.
    always_comb begin
        if (m_clk_en_r) begin
            if (t_r == T_LAST) begin
                t_nxt_s = {WINDOW_BITS{1'b0}};
            end else begin
                t_nxt_s = t_r + WINDOW_BITS'(1);
            end
            if (close_a_s) begin
                acc_a_nxt_s = {WINDOW_BITS{1'b0}};
            end else begin
                acc_a_nxt_s = sum_a_s;
            end
            // B clears at its close tick even before priming. This drops the
            // partial count gathered since reset.
            if (close_b_s) begin
                acc_b_nxt_s = {WINDOW_BITS{1'b0}};
            end else begin
                acc_b_nxt_s = sum_b_s;
            end
            if (t_r == B_START) begin
                b_primed_nxt_s = 1'b1;
            end else begin
                b_primed_nxt_s = b_primed_r;
            end
        end else begin
            t_nxt_s        = t_r;
            acc_a_nxt_s    = acc_a_r;
            acc_b_nxt_s    = acc_b_r;
            b_primed_nxt_s = b_primed_r;
        end
    end

    // Output word selection. A and B never close on the same tick.
    always_comb begin
        if (close_a_s) begin
            amplitude_nxt_s       = sum_a_s;
            amplitude_valid_nxt_s = 1'b1;
        end else if (close_b_s && b_primed_r) begin
            amplitude_nxt_s       = sum_b_s;
            amplitude_valid_nxt_s = 1'b1;
        end else begin
            amplitude_nxt_s       = amplitude_r;
            amplitude_valid_nxt_s = 1'b0;
        end
    end

    // State registers, including the 2-flop synchronizer on m_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r             <= {DIV_W{1'b0}};
            m_clk_r           <= 1'b0;
            m_clk_en_r        <= 1'b0;
            sync_meta_r       <= 1'b0;
            d_sync_r          <= 1'b0;
            t_r               <= {WINDOW_BITS{1'b0}};
            acc_a_r           <= {WINDOW_BITS{1'b0}};
            acc_b_r           <= {WINDOW_BITS{1'b0}};
            b_primed_r        <= 1'b0;
            amplitude_r       <= {WINDOW_BITS{1'b0}};
            amplitude_valid_r <= 1'b0;
        end else begin
            div_r             <= div_nxt_s;
            m_clk_r           <= m_clk_nxt_s;
            m_clk_en_r        <= m_clk_en_nxt_s;
            sync_meta_r       <= m_data;
            d_sync_r          <= sync_meta_r;
            t_r               <= t_nxt_s;
            acc_a_r           <= acc_a_nxt_s;
            acc_b_r           <= acc_b_nxt_s;
            b_primed_r        <= b_primed_nxt_s;
            amplitude_r       <= amplitude_nxt_s;
            amplitude_valid_r <= amplitude_valid_nxt_s;
        end
    end

endmodule

// File: tb/tb_pdm_mic_receiver.sv
// -----------------------------------------------------------------------------
// tb_pdm_mic_receiver
//
// Directed bench for pdm_mic_receiver at its default parameters (42-cycle mic
// clock, 127-tick windows). A negedge process does three jobs. It counts
// sample ticks since reset. It drives m_data for the next tick: constant,
// alternating, or a first-order sigma-delta modulator. It logs every strobe
// with its tick number and amplitude. It also counts protocol breaks: back-to-
// back strobes, amplitude moving without a strobe, and m_clk_en not aligned
// with the m_clk rise. The main sequence compares against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pdm_mic_receiver;

    localparam int HP = 21;
    localparam int MODE_CONST = 0;
    localparam int MODE_ALT   = 1;
    localparam int MODE_SD    = 2;

    logic       clk;
    logic       rst;
    logic       m_clk;
    logic       m_clk_en;
    logic       m_data;
    logic       m_lr_sel;
    logic [6:0] amplitude;
    logic       amplitude_valid;

    int checks   = 0;
    int failures = 0;

    // Stimulus configuration, written only by the main sequence.
    int   mode        = MODE_CONST;
    logic first_bit   = 1'b0;
    int   dens        = 32;
    int   dens_next   = 32;
    int   switch_tick = 0;

    // Monitor state, written only by the monitor process.
    int   tick_cnt = 0;
    int   viol     = 0;
    int   sd_acc   = 0;
    int   st_tick[$];
    int   st_amp[$];

    pdm_mic_receiver #(
        .HALF_PERIOD(HP),
        .WINDOW_BITS(7)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .m_clk          (m_clk),
        .m_clk_en       (m_clk_en),
        .m_data         (m_data),
        .m_lr_sel       (m_lr_sel),
        .amplitude      (amplitude),
        .amplitude_valid(amplitude_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // First-order sigma-delta modulator step at density d/127.
    task automatic sd_step(input int d, output logic b);
        sd_acc = sd_acc + d;
        if (sd_acc >= 127) begin
            sd_acc = sd_acc - 127;
            b = 1'b1;
        end else begin
            b = 1'b0;
        end
    endtask

    // Monitor and stimulus driver, on the falling edge.
    initial begin
        logic rst_prev;
        logic valid_prev;
        logic mclk_prev;
        logic [6:0] amp_prev;
        logic b;
        rst_prev   = 1'b1;
        valid_prev = 1'b0;
        mclk_prev  = 1'b0;
        amp_prev   = 7'd0;
        m_data     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tick_cnt = 0;
                st_tick.delete();
                st_amp.delete();
                if (mode == MODE_SD) begin
                    sd_acc = 0;
                    sd_step(dens, b);
                    m_data = b;
                end else begin
                    m_data = first_bit;
                end
            end else begin
                if (m_clk_en) begin
                    tick_cnt++;
                    case (mode)
                        MODE_ALT: m_data = ~m_data;
                        MODE_SD: begin
                            if (switch_tick != 0 && tick_cnt >= switch_tick) sd_step(dens_next, b);
                            else sd_step(dens, b);
                            m_data = b;
                        end
                        default: m_data = m_data;
                    endcase
                end
                if (amplitude_valid) begin
                    st_tick.push_back(tick_cnt);
                    st_amp.push_back(int'(amplitude));
                end
                if (!rst_prev) begin
                    if (amplitude_valid && valid_prev) viol++;
                    if (!amplitude_valid && amplitude != amp_prev) viol++;
                    if (m_clk_en != (m_clk && !mclk_prev)) viol++;
                end
            end
            rst_prev   = rst;
            valid_prev = amplitude_valid;
            mclk_prev  = m_clk;
            amp_prev   = amplitude;
        end
    end

    task automatic wait_tick(input int target, input string tag);
        int budget;
        budget = (target - tick_cnt) * 2 * HP + 200;
        while (tick_cnt < target && budget > 0) begin
            step();
            budget--;
        end
        check_eq(tag, tick_cnt, target);
        step();
        step();
    endtask

    task automatic start_phase(input int md, input logic fb, input int d0, input int d1, input int sw);
        rst         = 1'b1;
        mode        = md;
        first_bit   = fb;
        dens        = d0;
        dens_next   = d1;
        switch_tick = sw;
        repeat (3) step();
        rst = 1'b0;
    endtask

    int exp_ticks[4] = '{127, 191, 254, 318};
    int alt_amps[3]  = '{64, 64, 63};

    initial begin
        int n;
        int hi;
        int lo;
        int en_cnt;
        int nz;
        int viol_base;

        // Reset and mic clock
        rst = 1'b1;
        repeat (3) step();
        check_eq("rst_m_clk", int'(m_clk), 0);
        check_eq("rst_m_clk_en", int'(m_clk_en), 0);
        check_eq("rst_amplitude", int'(amplitude), 0);
        check_eq("rst_valid", int'(amplitude_valid), 0);
        check_eq("rst_lr_sel", int'(m_lr_sel), 0);
        repeat (2) step();
        rst = 1'b0;
        n = 0;
        while (m_clk !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check_eq("first_rise_cycle", n, HP);
        check_eq("first_rise_en", int'(m_clk_en), 1);
        hi = 0;
        while (m_clk === 1'b1 && hi < 200) begin
            hi++;
            step();
        end
        check_eq("m_clk_high_len", hi, HP);
        lo = 0;
        while (m_clk === 1'b0 && lo < 200) begin
            lo++;
            step();
        end
        check_eq("m_clk_low_len", lo, HP);
        en_cnt = 0;
        for (int i = 0; i < 2 * HP; i++) begin
            if (m_clk_en === 1'b1) en_cnt++;
            step();
        end
        check_eq("en_per_period", en_cnt, 1);
        check_eq("lr_sel_run", int'(m_lr_sel), 0);

        // All ones, reset pulse mid-window at tick 90, then a full run
        viol_base = viol;
        start_phase(MODE_CONST, 1'b1, 0, 0, 0);
        wait_tick(90, "ones_reach_90");
        check_eq("ones_no_strobe_pre90", st_tick.size(), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_tick(100, "rst_reach_100");
        check_eq("rst_amp_held_zero", int'(amplitude), 0);
        check_eq("rst_no_strobe_100", st_tick.size(), 0);
        wait_tick(256, "ones_reach_256");
        check_eq("ones_strobe_count", st_tick.size(), 3);
        if (st_tick.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("ones_tick%0d", i), st_tick[i], exp_ticks[i]);
                check_eq($sformatf("ones_amp%0d", i), st_amp[i], 127);
            end
            check_eq("ones_gap01", st_tick[1] - st_tick[0], 64);
            check_eq("ones_gap12", st_tick[2] - st_tick[1], 63);
        end
        check_eq("ones_protocol", viol - viol_base, 0);

        // All zeros for 1000 ticks
        viol_base = viol;
        start_phase(MODE_CONST, 1'b0, 0, 0, 0);
        wait_tick(1000, "zeros_reach_1000");
        check_eq("zeros_strobe_count", st_tick.size(), 14);
        nz = 0;
        foreach (st_amp[i]) if (st_amp[i] != 0) nz++;
        check_eq("zeros_nonzero_amps", nz, 0);
        check_eq("zeros_protocol", viol - viol_base, 0);

        // Alternating 1,0: tick k carries bit (k odd)
        viol_base = viol;
        start_phase(MODE_ALT, 1'b1, 0, 0, 0);
        wait_tick(256, "alt_reach_256");
        check_eq("alt_strobe_count", st_tick.size(), 3);
        if (st_tick.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("alt_tick%0d", i), st_tick[i], exp_ticks[i]);
                check_eq($sformatf("alt_amp%0d", i), st_amp[i], alt_amps[i]);
            end
            check_eq("alt_opposite_sum", st_amp[1] + st_amp[2], 127);
        end
        check_eq("alt_protocol", viol - viol_base, 0);

        // Sigma-delta 32/127, switched to 100/127 after tick 127
        viol_base = viol;
        start_phase(MODE_SD, 1'b0, 32, 100, 127);
        wait_tick(320, "sd_reach_320");
        check_eq("sd_strobe_count", st_tick.size(), 4);
        if (st_tick.size() == 4) begin
            check_eq("sd32_amp0_in_range", int'(st_amp[0] >= 31 && st_amp[0] <= 33), 1);
            check_eq("sd100_amp2_in_range", int'(st_amp[2] >= 99 && st_amp[2] <= 101), 1);
            check_eq("sd100_amp3_in_range", int'(st_amp[3] >= 99 && st_amp[3] <= 101), 1);
        end
        check_eq("sd_protocol", viol - viol_base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pdm_mic_receiver.md
# pdm_mic_receiver

PDM microphone receiver for the audio capture path. Generates the microphone bit clock and samples the 1-bit PDM stream. Converts the stream to unsigned amplitude words by counting ones over a 127-bit window. Two staggered windows give one new amplitude roughly every 64 bit-clock periods, in the same 0..127 density scale the team's PDM stimulus generator encodes.

## Interface
- HALF_PERIOD, 21: system clock cycles per half mic-clock period; must be ≥ 2. The default gives a 2.38 MHz mic clock from 100 MHz.
- WINDOW_BITS, 7: amplitude width. Window length W = 2^WINDOW_BITS − 1 mic-clock ticks (127 by default).

Ports:
- clk  in  1: system clock, 100 MHz.
- rst  in  1: synchronous, active-high reset.
- m_clk  out  1: microphone bit clock.
- m_clk_en  out  1: one-cycle pulse on each rising edge of m_clk (the sample tick).
- m_data  in  1: PDM data from the microphone, asynchronous to clk.
- m_lr_sel  out  1: channel select, tied to 0 (data valid at the m_clk rising edge).
- amplitude  out  WINDOW_BITS: count of ones in the last completed window.
- amplitude_valid  out  1: one-cycle strobe marking a new amplitude.

## Operation
- **Clock generator.**
  - Divider counter `div` runs 0..HALF_PERIOD−1.
  - When div == HALF_PERIOD−1: div ← 0 and m_clk toggles.
  - If m_clk is 0 in that cycle (a rising edge), m_clk_en ← 1 for the next cycle only.
- **Input synchronizer.** m_data passes through a 2-flop synchronizer to give `d_sync`.
- **Sampling.** On every cycle with m_clk_en == 1, the block samples d_sync as bit `b`.
- **Tick counter.**
  - `t` runs 0..W−1 and advances once per sample tick.
  - It wraps from W−1 to 0.
- **Accumulator A.**
  - Window is ticks t = 0..W−1.
  - On the tick with t == W−1: amplitude ← accA + b, accA ← 0, strobe.
  - On all other ticks: accA ← accA + b.
- **Accumulator B.**
  - Window starts at t = 2^(WINDOW_BITS−1) (64 by default) and closes at t = 2^(WINDOW_BITS−1) − 1 (63).
  - Closing and accumulation follow the same rule as A.
- **Priming flag.** `b_primed` is cleared by reset and set when B first starts a window (t == 64). B never strobes before b_primed is set, so a partial first window is suppressed.
- **Width rule.** Accumulators are WINDOW_BITS wide. The maximum value is W, so they never overflow and no saturation logic is needed.
- **Close collisions.** A and B never close on the same tick (the closing t values differ).
- **Reset.**
  - Values: div = 0, m_clk = 0, m_clk_en = 0, synchronizer = 0, t = 0, accA = accB = 0, b_primed = 0, amplitude = 0, amplitude_valid = 0. m_lr_sel = 0 always.
  - Reset asserted mid-window discards all partial counts.
  - Outputs hold their reset values until a full window completes after release.

## Timing
- **Mic clock.** Period is 2·HALF_PERIOD cycles with a 50% duty cycle.
  - First rising edge: m_clk goes high at cycle HALF_PERIOD after the first cycle with rst low.
  - m_clk_en is high in that same cycle.
- **Synchronizer latency.** The sampled bit equals the m_data level 2 clk cycles before the m_clk_en cycle.
  - Stimulus must hold m_data stable for ≥ 3 cycles before each rising edge.
- **Strobe latency.** amplitude and amplitude_valid update 1 cycle after the closing m_clk_en cycle.
- **Strobe spacing.** Strobes are alternately 64 and 63 ticks apart.
  - First A strobe follows tick 127, counting ticks from 1.
  - First B strobe follows tick 127 + 64 = 191.
- **Output hold.** amplitude holds its value between strobes. amplitude_valid is never high for two consecutive cycles.

## Test plan
1. **Reset / clock.** Hold rst for 5 cycles, then release.
   - All outputs are 0 during reset.
   - m_clk period is 42 cycles, high 21 / low 21.
   - m_clk_en pulses exactly once per 42 cycles, coincident with the m_clk rising edge.
2. **All ones.** m_data = 1 constant.
   - First strobe after tick 127 with amplitude = 127.
   - Next strobe after tick 191 with amplitude = 127.
   - Thereafter strobes alternate 64/63 ticks apart, all with amplitude 127.
3. **All zeros.** m_data = 0 constant.
   - Every strobe carries amplitude = 0.
   - Strobe count after 1000 ticks is 14.
4. **Alternating 1,0 per tick.**
   - Every amplitude is 63 or 64.
   - A and B values sum to 127 whenever their windows start on opposite phases.
5. **Sigma-delta stimulus.** Bench first-order modulator advanced on m_clk_en, density 32/127.
   - Every amplitude is within 31..33.
   - Then switch to density 100/127: amplitudes reach 99..101 within two strobes.
6. **Reset mid-window.** Drive all ones, then assert rst for 1 cycle at tick 90.
   - No strobe occurs for the next 126 ticks.
   - First post-reset strobe is 127 at tick 127.
   - No B strobe occurs before tick 191.
